// File: rtl/ocp_mem_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requesters onto one single-outstanding
// memory bridge, with per-transaction timeout and registered one-hot status pulses.
module ocp_mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_type,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_error,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic                          mem_access_request,
  output logic                          mem_access_type,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0]         mem_write_data,
  input  logic [DATA_WIDTH-1:0]         mem_read_data,
  input  logic                          mem_access_complete,
  input  logic                          bridge_busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [OW-1:0]           r_rr_ptr;
  logic [OW-1:0]           r_owner;
  logic [CW-1:0]           r_cnt;
  logic [NUM_REQ-1:0]      r_grant;
  logic [NUM_REQ-1:0]      r_done;
  logic [NUM_REQ-1:0]      r_error;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_mem_req;
  logic                    r_mem_type;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;

  logic [OW-1:0]           w_sel;
  logic [OW-1:0]           w_idx;
  logic                    w_found;
  logic                    w_start;
  logic                    w_timeout;
  logic [OW-1:0]           w_owner_inc;
  int                      w_tmp;

  // Scan upward from rr_ptr with wrap; the first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    w_tmp   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_tmp = int'(r_rr_ptr) + i;
      if (w_tmp >= NUM_REQ) begin
        w_tmp = w_tmp - NUM_REQ;
      end else begin
        w_tmp = w_tmp;
      end
      w_idx = OW'(w_tmp);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_start     = (r_state == S_IDLE) && w_found && !bridge_busy;
  assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));
  assign w_owner_inc = (r_owner == OW'(NUM_REQ - 1)) ? {OW{1'b0}} : (r_owner + OW'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_access_complete || w_timeout) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (enable) begin
      r_state <= w_state_nxt;
    end else begin
      r_state <= r_state;
    end
  end

  // Pulses are cleared while disabled so a stall never stretches one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_error     <= '0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_type  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (!enable) begin
      r_grant   <= '0;
      r_done    <= '0;
      r_error   <= '0;
      r_mem_req <= 1'b0;
    end else begin
      r_grant   <= '0;
      r_done    <= '0;
      r_error   <= '0;
      r_mem_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_grant     <= NUM_REQ'(1) << w_sel;
            r_owner     <= w_sel;
            r_mem_type  <= req_type[w_sel];
            r_mem_addr  <= req_addr[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
            r_mem_wdata <= req_wdata[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_ISSUE: begin
          r_mem_req <= 1'b1;
          r_cnt     <= '0;
        end
        S_WAIT: begin
          if (mem_access_complete) begin
            r_done   <= NUM_REQ'(1) << r_owner;
            r_rr_ptr <= w_owner_inc;
            if (!r_mem_type) begin
              r_rdata <= mem_read_data;
            end
          end else if (w_timeout) begin
            r_error  <= NUM_REQ'(1) << r_owner;
            r_rr_ptr <= w_owner_inc;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign req_grant          = r_grant;
  assign req_done           = r_done;
  assign req_error          = r_error;
  assign req_rdata          = r_rdata;
  assign mem_access_request = r_mem_req;
  assign mem_access_type    = r_mem_type;
  assign mem_address        = r_mem_addr;
  assign mem_write_data     = r_mem_wdata;
  assign owner              = r_owner;

endmodule
